// File: rtl/uart_hex_loader.sv
// Parses ASCII hex from the UART receiver into 32-bit words and writes them to instruction memory.
// Define HEXLD_ECHO_EN to echo every accepted byte through the UART transmitter.
module uart_hex_loader #(
    parameter int unsigned Depth = 16,
    parameter int unsigned AddrW = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_rdy_i,
    output logic             rx_rdy_clr_o,
    output logic [7:0]       tx_din_o,
    output logic             tx_wr_en_o,
    input  logic             tx_busy_i,
    input  logic             restart_i,
    output logic             imem_we_o,
    output logic [AddrW-1:0] imem_addr_o,
    output logic [31:0]      imem_wdata_o,
    output logic [AddrW:0]   word_count_o,
    output logic             load_done_o,
    output logic             err_o
);

    localparam logic [AddrW:0] DepthW = (AddrW+1)'(Depth);

`ifdef HEXLD_ECHO_EN
    typedef enum logic [2:0] {StIdle, StDecode, StEcho, StWrite, StDone} state_e;
`else
    typedef enum logic [2:0] {StIdle, StDecode, StWrite, StDone} state_e;
`endif

    state_e           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic [31:0]      word_q, word_d;
    logic [3:0]       nib_cnt_q, nib_cnt_d;
    logic [AddrW:0]   cnt_q, cnt_d, cnt_inc;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             rdy_clr_q, rdy_clr_d;
    logic             we_q, we_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             is_dig, is_hex, is_ws, is_dot;
    logic [3:0]       nib_val;

    // After a byte is processed: full word goes to WRITE, '.' ends the load.
    function automatic state_e exit_state(logic [3:0] nib, logic dot);
        if (nib == 4'd8) return StWrite;
        if (dot) return StDone;
        return StIdle;
    endfunction

    always_comb begin
        is_dig  = byte_q inside {[8'h30:8'h39]};
        is_hex  = is_dig || (byte_q inside {[8'h41:8'h46], [8'h61:8'h66]});
        is_ws   = byte_q inside {8'h20, 8'h09, 8'h0D, 8'h0A};
        is_dot  = (byte_q == 8'h2E);
        nib_val = is_dig ? byte_q[3:0] : byte_q[3:0] + 4'd9;
        cnt_inc = cnt_q + 1'b1;
    end

`ifdef HEXLD_ECHO_EN
    logic [7:0] tx_din_q, tx_din_d;
    logic       tx_wr_en_q, tx_wr_en_d;
`else
    logic       unused_tx_busy;
    assign unused_tx_busy = tx_busy_i;
`endif

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        word_d    = word_q;
        nib_cnt_d = nib_cnt_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        err_d     = err_q;
        rdy_clr_d = 1'b0;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
`ifdef HEXLD_ECHO_EN
        tx_din_d   = tx_din_q;
        tx_wr_en_d = 1'b0;
`endif
        if (restart_i) begin
            state_d   = StIdle;
            word_d    = '0;
            nib_cnt_d = '0;
            cnt_d     = '0;
            done_d    = 1'b0;
            err_d     = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rx_rdy_i) begin
                        byte_d    = rx_data_i;
                        rdy_clr_d = 1'b1;
                        state_d   = StDecode;
                    end
                end
                StDecode: begin
                    if (is_hex) begin
                        word_d    = {word_q[27:0], nib_val};
                        nib_cnt_d = nib_cnt_q + 4'd1;
                    end else if (is_dot) begin
                        done_d    = 1'b1;
                        word_d    = '0;
                        nib_cnt_d = '0;
                    end else if (!is_ws) begin
                        err_d     = 1'b1;
                        word_d    = '0;
                        nib_cnt_d = '0;
                    end
`ifdef HEXLD_ECHO_EN
                    state_d = StEcho;
`else
                    state_d = exit_state(nib_cnt_d, is_dot);
`endif
                end
`ifdef HEXLD_ECHO_EN
                StEcho: begin
                    if (!tx_busy_i) begin
                        tx_wr_en_d = 1'b1;
                        tx_din_d   = byte_q;
                        state_d    = exit_state(nib_cnt_q, is_dot);
                    end
                end
`endif
                StWrite: begin
                    we_d      = 1'b1;
                    addr_d    = cnt_q[AddrW-1:0];
                    wdata_d   = word_q;
                    nib_cnt_d = '0;
                    cnt_d     = cnt_inc;
                    if (cnt_inc == DepthW) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StDone: begin
                    // rx_rdy is still high in the cycle its clear pulse is out
                    if (rx_rdy_i && !rdy_clr_q) rdy_clr_d = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            byte_q    <= '0;
            word_q    <= '0;
            nib_cnt_q <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdy_clr_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            word_q    <= word_d;
            nib_cnt_q <= nib_cnt_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdy_clr_q <= rdy_clr_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

`ifdef HEXLD_ECHO_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tx_din_q   <= '0;
            tx_wr_en_q <= 1'b0;
        end else begin
            tx_din_q   <= tx_din_d;
            tx_wr_en_q <= tx_wr_en_d;
        end
    end
    assign tx_din_o   = tx_din_q;
    assign tx_wr_en_o = tx_wr_en_q;
`else
    assign tx_din_o   = '0;
    assign tx_wr_en_o = 1'b0;
`endif

    assign rx_rdy_clr_o = rdy_clr_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign word_count_o = cnt_q;
    assign load_done_o  = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_uart_hex_loader.sv
// Scoreboard bench for uart_hex_loader: a byte-level model queues expected writes and echoes.
module tb_uart_hex_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_rdy = 1'b0;
    logic        rx_rdy_clr;
    logic [7:0]  tx_din;
    logic        tx_wr_en;
    logic        tx_busy = 1'b0;
    logic        restart = 1'b0;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [4:0]  word_count;
    logic        load_done;
    logic        err;

    uart_hex_loader dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_data_i   (rx_data),
        .rx_rdy_i    (rx_rdy),
        .rx_rdy_clr_o(rx_rdy_clr),
        .tx_din_o    (tx_din),
        .tx_wr_en_o  (tx_wr_en),
        .tx_busy_i   (tx_busy),
        .restart_i   (restart),
        .imem_we_o   (imem_we),
        .imem_addr_o (imem_addr),
        .imem_wdata_o(imem_wdata),
        .word_count_o(word_count),
        .load_done_o (load_done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] eq[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         clr_cnt = 0;
    int         tx_cnt = 0;
`ifdef HEXLD_ECHO_EN
    localparam bit Echo = 1'b1;
`else
    localparam bit Echo = 1'b0;
`endif

    logic [31:0] m_word;
    logic [3:0]  m_nib;
    logic [4:0]  m_cnt;
    logic        m_done, m_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_word = '0; m_nib = '0; m_cnt = '0; m_done = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [3:0] v;
        if (m_done) return;
        if (Echo) eq.push_back(b);
        if ((b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
            (b >= 8'h61 && b <= 8'h66)) begin
            if (b <= 8'h39) v = 4'(b - 8'h30);
            else if (b <= 8'h46) v = 4'(b - 8'h37);
            else v = 4'(b - 8'h57);
            m_word = {m_word[27:0], v};
            m_nib++;
            if (m_nib == 4'd8) begin
                wq.push_back('{addr: m_cnt[3:0], data: m_word});
                m_nib = '0;
                m_cnt++;
                if (m_cnt == 5'd16) m_done = 1'b1;
            end
        end else if (b == 8'h2E) begin
            m_done = 1'b1; m_nib = '0;
        end else if (!(b inside {8'h20, 8'h09, 8'h0D, 8'h0A})) begin
            m_err = 1'b1; m_nib = '0;
        end
    endtask

    // UART receiver behaviour: rx_rdy drops on the edge after rx_rdy_clr is seen.
    task automatic wait_clr(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (rx_rdy_clr) return;
        end
        check({tag, "_clr_timeout"}, 0, 1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        model_byte(b);
        wait_clr("send");
        @(posedge clk); #1;
        rx_rdy = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        model_clear();
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, word_count, m_cnt);
        check({tag, "_err"}, err, m_err);
        check({tag, "_done"}, load_done, m_done);
    endtask

    task automatic check_zero_outs(input string tag);
        check(tag, {rx_rdy_clr, tx_din, tx_wr_en, imem_we, imem_addr, imem_wdata, word_count,
                    load_done, err}, 0);
    endtask

    always @(negedge clk) begin
        wr_t        w;
        logic [7:0] e;
        if (rx_rdy_clr) clr_cnt++;
        if (imem_we) begin
            if (wq.size() == 0) begin
                check("unexpected_we", 1, 0);
            end else begin
                w = wq.pop_front();
                check("we_addr", imem_addr, w.addr);
                check("we_data", imem_wdata, w.data);
            end
        end
        if (tx_wr_en) begin
            tx_cnt++;
            if (eq.size() == 0) begin
                check("unexpected_tx", 1, 0);
            end else begin
                e = eq.pop_front();
                check("echo_byte", tx_din, e);
            end
        end
    end

    initial begin
        int    c0, t0;
        string hs;
        hs = "0123456789abcdefABCDEF";
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_zero_outs("reset_outs");
        rst_n = 1'b1;

        // Single word with echo of every byte.
        t0 = tx_cnt;
        send_str("DEADBEEF");
        settle();
        check_status("deadbeef");
        check("deadbeef_tx", tx_cnt - t0, Echo ? 8 : 0);
        check("deadbeef_wq", wq.size(), 0);

        // Whitespace between and inside words.
        do_restart();
        check_status("restart1");
        send_str("0000 0013\r\n00100093");
        settle();
        check_status("ws");

        // Invalid character drops the partial word.
        do_restart();
        send_str("12G");
        settle();
        check_status("bad_char");
        send_str("4abcdef01");
        settle();
        check_status("after_bad");

        // Fill memory, then extra bytes are consumed but ignored.
        do_restart();
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 8; j++) send_byte(hs[(i + j) % 22]);
        settle();
        check_status("full");
        c0 = clr_cnt;
        t0 = tx_cnt;
        send_str("11111111");
        settle();
        check("full_extra_clr", clr_cnt - c0, 8);
        check("full_extra_tx", tx_cnt - t0, 0);
        check_status("full_extra");

        // '.' ends the load; restart with rx_rdy high does not consume the byte.
        do_restart();
        send_str("AB?C.");
        settle();
        check_status("dot");
        rx_data = 8'h35;
        rx_rdy  = 1'b1;
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        model_clear();
        check("restart_no_clr", rx_rdy_clr, 0);
        check_status("restart_dot");
        model_byte(8'h35);
        wait_clr("after_restart");
        @(posedge clk); #1;
        rx_rdy = 1'b0;
        settle();

        // Transmitter busy stalls byte processing only when echo is built in.
        do_restart();
        tx_busy = 1'b1;
        send_byte(8'h37);
        c0 = clr_cnt;
        t0 = tx_cnt;
        if (Echo) begin
            rx_data = 8'h38;
            rx_rdy  = 1'b1;
            model_byte(8'h38);
            repeat (100) @(posedge clk);
            #1;
            check("busy_clr", clr_cnt - c0, 0);
            check("busy_tx", tx_cnt - t0, 0);
            tx_busy = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check("unbusy_tx", tx_cnt - t0, 1);
            check("unbusy_clr", rx_rdy_clr, 1);
            @(posedge clk); #1;
            rx_rdy = 1'b0;
        end else begin
            send_byte(8'h38);
            repeat (100) @(posedge clk);
            #1;
            check("busy_ignored_clr", clr_cnt - c0, 1);
            check("busy_ignored_tx", tx_cnt - t0, 0);
            tx_busy = 1'b0;
        end
        settle();

        // Reset in the middle of a word.
        send_str("1234");
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outs("midword_reset");
        model_clear();
        eq.delete();
        rst_n = 1'b1;
        send_str("CAFEF00D");
        settle();
        check_status("recover");

        check("final_wq", wq.size(), 0);
        check("final_eq", eq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
